// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared opcode constants, branch encodings and fetch state type
package fetch_unit_pkg;

  localparam logic [3:0] OP_NOP     = 4'b0000;
  localparam logic [3:0] OP_LOADIMM = 4'b1111;

  localparam logic [1:0] BC_BR  = 2'd0;
  localparam logic [1:0] BC_BRC = 2'd1;
  localparam logic [1:0] BC_SUB = 2'd2;
  localparam logic [1:0] BC_RET = 2'd3;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_FAULT = 2'd2
  } fetchState_t;

endpackage

// File: rtl/fetch_unit_link_stack.sv
// rtl/fetch_unit_link_stack.sv - subroutine link storage for the fetch unit
// FETCH_LINK_STACK_EN selects a DEPTH-entry LIFO; otherwise a single register plus valid bit.
module link_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] pushData,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

`ifdef FETCH_LINK_STACK_EN
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (push && !full) begin
      mem[IW'(count)] <= pushData;
      count           <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  assign top   = mem[IW'(count - CW'(1))];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
`else
  logic [W-1:0] linkReg;
  logic         linkValid;

  // A new BR.SUB simply overwrites the saved link.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      linkValid <= 1'b0;
    end else if (push) begin
      linkReg   <= pushData;
      linkValid <= 1'b1;
    end else if (pop) begin
      linkValid <= 1'b0;
    end
  end

  assign top   = linkReg;
  assign full  = (DEPTH < 1);
  assign empty = !linkValid;
`endif

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch and PC sequencer with subroutine link save/restore
// Optional FETCH_LINK_STACK_EN turns the single link register into a LINK_DEPTH-entry stack.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int INSTR_W    = 16,
  parameter int LINK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               use_ea,
  input  logic               link_src,
  input  logic [1:0]         branch_control,
  input  logic               cond_flag,
  output logic               instr_valid,
  output logic [3:0]         opcode,
  output logic [ADDR_W-1:0]  ea,
  output logic [ADDR_W-1:0]  pc,
  output logic               fault
);

  fetchState_t        state;
  logic [INSTR_W-1:0] instrReg;
  logic [ADDR_W-1:0]  pcReg;
  logic               faultReg;

  logic [ADDR_W-1:0]  pcPlusOne;
  logic [ADDR_W-1:0]  nextPc;
  logic [ADDR_W-1:0]  linkTop;
  logic               linkFull;
  logic               linkEmpty;
  logic               linkPush;
  logic               linkPop;
  logic               linkFault;
  logic               execDone;
  logic               unusedIrBits;

  assign pcPlusOne = pcReg + ADDR_W'(1);
  assign execDone  = (state == ST_EXEC) && !stall;

  always_comb begin
    nextPc    = pcPlusOne;
    linkPush  = 1'b0;
    linkPop   = 1'b0;
    linkFault = 1'b0;
    // A branch only acts when the decoder marks the opcode as both EA-using and link-sourcing.
    if (execDone && use_ea && link_src) begin
      case (branch_control)
        BC_BR:  nextPc = ea;
        BC_BRC: if (cond_flag) nextPc = ea;
        BC_SUB: begin
          if (linkFull) begin
            linkFault = 1'b1;
          end else begin
            linkPush = 1'b1;
            nextPc   = ea;
          end
        end
        default: begin
          if (linkEmpty) begin
            linkFault = 1'b1;
          end else begin
            linkPop = 1'b1;
            nextPc  = linkTop;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_FETCH;
      pcReg    <= '0;
      instrReg <= {OP_NOP, {(INSTR_W-4){1'b0}}};
      faultReg <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            instrReg <= imem_data;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            if (linkFault) begin
              faultReg <= 1'b1;
              state    <= ST_FAULT;
            end else begin
              pcReg <= nextPc;
              state <= ST_FETCH;
            end
          end
        end
        default: state <= ST_FAULT;
      endcase
    end
  end

  link_stack #(
    .DEPTH (LINK_DEPTH),
    .W     (ADDR_W)
  ) u_link_stack (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (linkPush),
    .pop      (linkPop),
    .pushData (pcPlusOne),
    .top      (linkTop),
    .full     (linkFull),
    .empty    (linkEmpty)
  );

  // The request is masked during reset so an in-flight fetch is abandoned immediately.
  assign imem_req     = reset_n && (state == ST_FETCH);
  assign imem_addr    = pcReg;
  assign instr_valid  = (state == ST_EXEC);
  assign opcode       = instrReg[INSTR_W-1 -: 4];
  assign ea           = instrReg[ADDR_W-1:0];
  assign pc           = pcReg;
  assign fault        = faultReg;
  assign unusedIrBits = ^instrReg;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: vector table, hand sequences, random vs model
module tb_fetch_unit;
  import fetch_unit_pkg::*;

`ifdef FETCH_LINK_STACK_EN
  localparam int LINK_CAP       = 4;
  localparam bit LINK_OVERWRITE = 1'b0;
`else
  localparam int LINK_CAP       = 1;
  localparam bit LINK_OVERWRITE = 1'b1;
`endif

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        stall;
  logic        use_ea;
  logic        link_src;
  logic [1:0]  branch_control;
  logic        cond_flag;
  logic        instr_valid;
  logic [3:0]  opcode;
  logic [7:0]  ea;
  logic [7:0]  pc;
  logic        fault;

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .LINK_DEPTH(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .stall          (stall),
    .use_ea         (use_ea),
    .link_src       (link_src),
    .branch_control (branch_control),
    .cond_flag      (cond_flag),
    .instr_valid    (instr_valid),
    .opcode         (opcode),
    .ea             (ea),
    .pc             (pc),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          nCmp = 0;
  int          nBad = 0;
  logic [15:0] mem [256];

  // Reference model state: program counter, link contents as a queue, sticky fault.
  int pcM;
  int linkQ[$];
  bit faultM;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] word;
    int          waits;
    int          stalls;
    bit          useEa;
    bit          linkSrc;
    logic [1:0]  bc;
    bit          cond;
    logic [7:0]  expNext;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int cycles);
    reset_n   = 1'b0;
    imem_ack  = 1'b1;
    imem_data = 16'hFFFF;
    #1;
    check("reset_req_low", imem_req, 0);
    for (int i = 0; i < cycles; i++) tick();
    reset_n  = 1'b1;
    imem_ack = 1'b0;
    #1;
    check("rst_req", imem_req, 1);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_fault", fault, 0);
    check("rst_opcode", opcode, 0);
    check("rst_ea", ea, 0);
    pcM    = 0;
    faultM = 1'b0;
    linkQ.delete();
  endtask

  task automatic fetchExec(input int waits, input int stalls, input bit useEaIn, input bit linkSrcIn,
                           input logic [1:0] bcIn, input bit condIn,
                           output logic [7:0] gotNext, output bit gotFault);
    int          expPc;
    logic [15:0] w;
    int          nxt;
    bit          flt;
    expPc = pcM;
    w     = mem[expPc];
    for (int i = 0; i <= waits; i++) begin
      check("fetch_req", imem_req, 1);
      check("fetch_addr", imem_addr, expPc);
      check("fetch_valid", instr_valid, 0);
      imem_ack  = (i == waits);
      imem_data = (i == waits) ? mem[imem_addr] : 16'($urandom);
      tick();
    end
    for (int s = 0; s <= stalls; s++) begin
      check("exec_valid", instr_valid, 1);
      check("exec_req", imem_req, 0);
      check("exec_opcode", opcode, w[15:12]);
      check("exec_ea", ea, w[7:0]);
      check("exec_pc", pc, expPc);
      imem_ack  = 1'($urandom);
      imem_data = 16'($urandom);
      stall     = (s < stalls);
      if (s < stalls) begin
        use_ea         = 1'b1;
        link_src       = 1'b1;
        branch_control = 2'($urandom);
        cond_flag      = 1'($urandom);
      end else begin
        use_ea         = useEaIn;
        link_src       = linkSrcIn;
        branch_control = bcIn;
        cond_flag      = condIn;
      end
      tick();
    end
    stall    = 1'b0;
    imem_ack = 1'b0;

    flt = 1'b0;
    nxt = (expPc + 1) % 256;
    if (useEaIn && linkSrcIn) begin
      case (bcIn)
        BC_BR:  nxt = w[7:0];
        BC_BRC: if (condIn) nxt = w[7:0];
        BC_SUB: begin
          if (!LINK_OVERWRITE && linkQ.size() >= LINK_CAP) flt = 1'b1;
          else begin
            if (LINK_OVERWRITE) linkQ.delete();
            linkQ.push_back((expPc + 1) % 256);
            nxt = w[7:0];
          end
        end
        default: begin
          if (linkQ.size() == 0) flt = 1'b1;
          else nxt = linkQ.pop_back();
        end
      endcase
    end

    if (flt) begin
      faultM = 1'b1;
      check("fault_set", fault, 1);
      check("fault_req", imem_req, 0);
      check("fault_valid", instr_valid, 0);
      check("fault_pc", pc, expPc);
    end else begin
      pcM = nxt;
      check("next_fault", fault, 0);
      check("next_req", imem_req, 1);
      check("next_addr", imem_addr, nxt);
    end
    gotNext  = imem_addr;
    gotFault = fault;
  endtask

  function automatic vec_t mk(input logic [7:0] p, input logic [15:0] wd, input int wt, input int st,
                              input bit u, input bit l, input logic [1:0] b, input bit c,
                              input logic [7:0] en);
    vec_t v;
    v.pc = p; v.word = wd; v.waits = wt; v.stalls = st;
    v.useEa = u; v.linkSrc = l; v.bc = b; v.cond = c; v.expNext = en;
    return v;
  endfunction

  initial begin
    logic [7:0] nx;
    bit         ft;

    vecs[0]  = mk(8'h00, 16'h1000, 0, 0, 0, 0, BC_BR,  0, 8'h01);
    vecs[1]  = mk(8'h01, 16'h2000, 0, 0, 0, 0, BC_BR,  0, 8'h02);
    vecs[2]  = mk(8'h02, 16'h0000, 0, 0, 0, 0, BC_BR,  0, 8'h03);
    vecs[3]  = mk(8'h03, 16'h5000, 1, 0, 0, 1, BC_BR,  0, 8'h04);
    vecs[4]  = mk(8'h04, 16'h8020, 0, 0, 1, 1, BC_BRC, 0, 8'h05);
    vecs[5]  = mk(8'h05, 16'h1000, 3, 0, 0, 0, BC_BR,  0, 8'h06);
    vecs[6]  = mk(8'h06, 16'h9004, 0, 1, 1, 1, BC_BR,  0, 8'h04);
    vecs[7]  = mk(8'h04, 16'h8020, 0, 0, 1, 1, BC_BRC, 1, 8'h20);
    vecs[8]  = mk(8'h20, 16'hA010, 0, 0, 1, 1, BC_BR,  0, 8'h10);
    vecs[9]  = mk(8'h10, 16'hB040, 0, 0, 1, 1, BC_SUB, 0, 8'h40);
    vecs[10] = mk(8'h40, 16'hC000, 2, 1, 1, 1, BC_RET, 0, 8'h11);
    vecs[11] = mk(8'h11, 16'h4000, 0, 0, 1, 0, BC_BR,  0, 8'h12);
    vecs[12] = mk(8'h12, 16'h40FF, 0, 0, 0, 1, BC_BR,  0, 8'h13);
    vecs[13] = mk(8'h13, 16'h70FF, 0, 0, 1, 1, BC_BR,  1, 8'hFF);
    vecs[14] = mk(8'hFF, 16'h1234, 0, 2, 0, 0, BC_BR,  0, 8'h00);

    reset_n = 1'b0; imem_ack = 1'b0; imem_data = '0; stall = 1'b0;
    use_ea = 1'b0; link_src = 1'b0; branch_control = BC_BR; cond_flag = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
    tick();
    doReset(2);

    foreach (vecs[i]) mem[vecs[i].pc] = vecs[i].word;
    for (int i = 0; i < 15; i++) begin
      check("tbl_start_addr", imem_addr, vecs[i].pc);
      fetchExec(vecs[i].waits, vecs[i].stalls, vecs[i].useEa, vecs[i].linkSrc,
                vecs[i].bc, vecs[i].cond, nx, ft);
      check("tbl_next_addr", nx, vecs[i].expNext);
      check("tbl_no_fault", ft, 0);
    end

    // RETURN straight after reset: empty link faults and only reset recovers.
    doReset(1);
    mem[0] = 16'hC000;
    fetchExec(0, 0, 1, 1, BC_RET, 0, nx, ft);
    check("ret_empty_fault", ft, 1);
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1;
      tick();
      check("fault_sticky", fault, 1);
      check("fault_hold_req", imem_req, 0);
      check("fault_hold_pc", pc, 0);
    end
    doReset(1);
    mem[0] = 16'h1000;
    fetchExec(0, 0, 0, 0, BC_BR, 0, nx, ft);
    check("recover_next", nx, 8'h01);

    // Five nested BR.SUB calls from address 0.
    doReset(1);
    for (int i = 0; i < 5; i++) mem[i] = {8'hB0, 8'(i + 1)};
    mem[5] = 16'hC000;
    for (int i = 0; i < 5; i++) fetchExec(0, 0, 1, 1, BC_SUB, 0, nx, ft);
`ifdef FETCH_LINK_STACK_EN
    check("nest_fault", fault, 1);
    check("nest_req", imem_req, 0);
    check("nest_pc", pc, 4);
`else
    check("nest_no_fault", fault, 0);
    check("nest_addr", imem_addr, 5);
    fetchExec(0, 0, 1, 1, BC_RET, 0, nx, ft);
    check("ret_latest_link", nx, 8'h05);
    fetchExec(0, 0, 1, 1, BC_RET, 0, nx, ft);
    check("ret_cleared_fault", ft, 1);
`endif

    // Random program and decoder outputs against the model.
    doReset(1);
    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
    for (int n = 0; n < 300; n++) begin
      fetchExec($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom), nx, ft);
      if (faultM) doReset(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
